// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path definitions: default widths, reset PC and the
// PC/instruction pair stored in the prefetch FIFO.
package fetch_unit_pkg;

  localparam int CORE_XLEN = 32;
  localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
  parameter int XLEN    = 32,
  parameter int MAX_OUT = 2
);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc4;
  logic [CW-1:0]   inflight;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_instr, dec_pc, dec_pc4, inflight
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_instr, dec_pc, dec_pc4, inflight
  );

endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush, simultaneous push/pop and occupancy count.
// Flush has priority over any push or pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    count_o = count_q;
    data_o  = mem_q[rdPtr_q];
    doPop   = pop_i && !flush_i && !empty_o;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    doPush  = push_i && !flush_i && (!full_o || doPop);
  end

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      if (doPush && !doPop) count_d = count_q + CW'(1);
      if (doPop && !doPush) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited pipelined requests to a
// variable-latency memory, a prefetch FIFO to decode, and redirect flushing.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = CORE_XLEN,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC
) (
  input logic          clk,
  input logic          resetn,
  fetch_unit_if.master bus
);

  localparam int CW  = $clog2(MAX_OUT + 1);
  localparam int FCW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetchPc_q, fetchPc_d, respPc_q, respPc_d;
  logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d;
  logic [FCW-1:0]  fifoCount;
  logic            fifoFull, fifoEmpty;
  logic            grant, respOk, push, pop;
  int              occupancy;
  fetch_entry_t    pushEntry, headEntry;

  // Occupancy counts buffered words plus responses that will still be kept,
  // so a request is only issued when its word is guaranteed a FIFO slot.
  always_comb begin
    occupancy     = int'(fifoCount) + int'(inflight_q) - int'(discard_q);
    bus.imem_req  = resetn && !bus.redirect && !fifoFull &&
                    (inflight_q < CW'(MAX_OUT)) && (occupancy < DEPTH);
    bus.imem_addr = fetchPc_q;
    bus.dec_valid = !fifoEmpty && !bus.redirect;
    bus.dec_instr = headEntry.instr;
    bus.dec_pc    = headEntry.pc;
    bus.dec_pc4   = headEntry.pc + XLEN'(4);
    bus.inflight  = inflight_q;
  end

  always_comb begin
    grant           = bus.imem_req && bus.imem_gnt;
    respOk          = bus.imem_rvalid && (inflight_q != '0);
    push            = respOk && (discard_q == '0) && !bus.redirect;
    pop             = bus.dec_valid && bus.dec_ready;
    pushEntry.pc    = respPc_q;
    pushEntry.instr = bus.imem_rdata;
  end

  always_comb begin
    fetchPc_d  = fetchPc_q;
    respPc_d   = respPc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (grant) begin
      fetchPc_d  = fetchPc_q + XLEN'(4);
      inflight_d = inflight_d + CW'(1);
    end
    if (respOk) begin
      inflight_d = inflight_d - CW'(1);
      if (discard_q != '0) discard_d = discard_q - CW'(1);
      else if (!bus.redirect) respPc_d = respPc_q + XLEN'(4);
    end
    // Stale responses are already part of inflight, so after a redirect the
    // discard count is simply everything still pending.
    if (bus.redirect) begin
      fetchPc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      respPc_d  = {bus.redirect_pc[XLEN-1:2], 2'b00};
      discard_d = inflight_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetchPc_q  <= RESET_PC;
      respPc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      respPc_q   <= respPc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i (bus.redirect),
    .push_i  (push),
    .data_i  (pushEntry),
    .pop_i   (pop),
    .data_o  (headEntry),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a queue-based model of outstanding
// requests (with stale marking) and of decode-visible words predicts outputs.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  typedef struct { logic [31:0] pc; bit stale; } req_t;
  typedef struct { logic [31:0] addr; int readyCycle; } mem_t;

  logic clk;
  logic resetn;

  fetch_unit_if #(.XLEN(XLEN), .MAX_OUT(MAX_OUT)) bus ();

  fetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          cycle       = 0;
  req_t        outQ[$];
  logic [31:0] fifoQ[$];
  logic [31:0] refFetchPc;
  mem_t        memPend[$];
  logic        lastReq, lastValid;
  logic [31:0] lastPc;
  int          lastInflight;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_req", bus.imem_req, 1'b0);
    checkOutput("rst_valid", bus.dec_valid, 1'b0);
    checkOutput("rst_inflight", bus.inflight, 0);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.dec_ready   = 1'b0;
    bus.redirect    = 1'b0;
    repeat (2) @(negedge clk);
    outQ.delete();
    fifoQ.delete();
    memPend.delete();
    refFetchPc = 32'h0000_0000;
    resetn = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the memory environment and the model by the cycle's events.
  task automatic applyStimulus(input bit gnt, input bit ready, input bit redir, input logic [31:0] rpc,
                               input int latMin, input int latMax, input int rvPct);
    bit          rv, expReq, expValid;
    logic [31:0] rdata, headPc4;
    req_t        r;
    int          nonStale;
    @(negedge clk);
    rv    = 1'b0;
    rdata = '0;
    if (memPend.size() > 0 && memPend[0].readyCycle <= cycle && int'($urandom_range(0, 99)) < rvPct) begin
      rv    = 1'b1;
      rdata = memData(memPend[0].addr);
    end
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdata;
    bus.dec_ready   = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    nonStale = 0;
    foreach (outQ[i]) if (!outQ[i].stale) nonStale++;
    expReq   = !redir && outQ.size() < MAX_OUT && (fifoQ.size() + nonStale) < DEPTH;
    expValid = fifoQ.size() > 0 && !redir;
    checkOutput("imem_req", bus.imem_req, expReq);
    if (expReq) checkOutput("imem_addr", bus.imem_addr, refFetchPc);
    checkOutput("dec_valid", bus.dec_valid, expValid);
    if (expValid) begin
      headPc4 = fifoQ[0] + 32'd4;
      checkOutput("dec_pc", bus.dec_pc, fifoQ[0]);
      checkOutput("dec_instr", bus.dec_instr, memData(fifoQ[0]));
      checkOutput("dec_pc4", bus.dec_pc4, headPc4);
    end
    checkOutput("inflight", bus.inflight, outQ.size());
    lastReq      = bus.imem_req;
    lastValid    = bus.dec_valid;
    lastPc       = bus.dec_pc;
    lastInflight = int'(bus.inflight);

    if (rv) void'(memPend.pop_front());
    if (bus.imem_req && bus.imem_gnt)
      memPend.push_back('{addr: bus.imem_addr, readyCycle: cycle + int'($urandom_range(latMin, latMax))});

    if (expValid && ready) void'(fifoQ.pop_front());
    if (rv && outQ.size() > 0) begin
      r = outQ.pop_front();
      if (!r.stale && !redir) fifoQ.push_back(r.pc);
    end
    if (expReq && gnt) begin
      outQ.push_back('{pc: refFetchPc, stale: 1'b0});
      refFetchPc = refFetchPc + 32'd4;
    end
    if (redir) begin
      fifoQ.delete();
      foreach (outQ[i]) outQ[i].stale = 1'b1;
      refFetchPc = {rpc[31:2], 2'b00};
    end
    cycle++;
  endtask

  initial begin
    bit          hit;
    logic [31:0] seenPc[$];
    logic [31:0] rpc;
    resetn          = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.dec_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    refFetchPc      = 32'h0;

    applyReset();

    // Single-cycle memory, decode always ready.
    repeat (40) applyStimulus(1, 1, 0, 32'h0, 1, 1, 100);

    // Decode stalled long enough to fill the FIFO completely.
    repeat (20) applyStimulus(1, 0, 0, 32'h0, 1, 1, 100);
    checkOutput("stall_req", lastReq, 1'b0);
    checkOutput("stall_valid", lastValid, 1'b1);
    checkOutput("stall_inflight", lastInflight, 0);
    repeat (10) applyStimulus(1, 1, 0, 32'h0, 1, 1, 100);

    // Three-cycle memory latency against the outstanding limit.
    repeat (40) begin
      applyStimulus(1, 1, 0, 32'h0, 3, 3, 100);
      checkOutput("inflight_cap", lastInflight <= MAX_OUT, 1'b1);
    end

    // Redirect to an unaligned target with requests in flight and words buffered.
    applyReset();
    for (int i = 0; i < 20 && !(fifoQ.size() == 2 && outQ.size() == 2); i++)
      applyStimulus(1, 0, 0, 32'h0, 2, 2, 100);
    applyStimulus(1, 1, 1, 32'h0000_0103, 2, 2, 100);
    checkOutput("redir_valid", lastValid, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      applyStimulus(1, 1, 0, 32'h0, 2, 2, 100);
      if (lastValid) begin
        hit = 1'b1;
        checkOutput("redir_target", lastPc, 32'h0000_0100);
      end
    end
    if (!hit) checkOutput("redir_timeout", 1'b0, 1'b1);

    // Redirect during steady streaming (response and pop coincide), then wrap.
    repeat (10) applyStimulus(1, 1, 0, 32'h0, 1, 1, 100);
    applyStimulus(1, 1, 1, 32'hFFFF_FFF8, 1, 1, 100);
    for (int i = 0; i < 40 && seenPc.size() < 3; i++) begin
      applyStimulus(1, 1, 0, 32'h0, 1, 1, 100);
      if (lastValid) seenPc.push_back(lastPc);
    end
    if (seenPc.size() == 3) begin
      checkOutput("wrap_pc0", seenPc[0], 32'hFFFF_FFF8);
      checkOutput("wrap_pc1", seenPc[1], 32'hFFFF_FFFC);
      checkOutput("wrap_pc2", seenPc[2], 32'h0000_0000);
    end else begin
      checkOutput("wrap_timeout", seenPc.size(), 3);
    end

    // Random traffic: grant gaps, decode stalls, redirects, variable latency.
    for (int i = 0; i < 800; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | $urandom_range(0, 31)) : $urandom;
      applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                    $urandom_range(0, 99) < 5, rpc, 1, 4, 70);
    end

    // Asynchronous reset in the middle of a burst.
    repeat (6) applyStimulus(1, 1, 0, 32'h0, 2, 2, 100);
    applyReset();
    repeat (30) applyStimulus(1, 1, 0, 32'h0, 1, 3, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
